// File: rtl/vscale_htif_tohost_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : vscale_htif_tohost_monitor_if
// Brief    : HTIF PCR request/response bundle between the tohost poller and core.
// Revision : 1.0  initial release
// ============================================================================
interface vscale_htif_tohost_monitor_if #(
  parameter int HTIF_PCR_WIDTH = 64,
  parameter int CSR_ADDR_WIDTH = 12
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_rw;
  logic [CSR_ADDR_WIDTH-1:0] req_addr;
  logic [HTIF_PCR_WIDTH-1:0] req_data;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [HTIF_PCR_WIDTH-1:0] resp_data;

  modport master (
    output req_valid, req_rw, req_addr, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_data, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface
`default_nettype wire

// File: rtl/vscale_htif_tohost_monitor.sv
`default_nettype none
// ============================================================================
// Module   : vscale_htif_tohost_monitor
// Brief    : Polls tohost over HTIF PCR, latches sticky pass/fail/timeout status.
// Option   : VSCALE_TOHOST_CLEAR_EN adds one clearing write of tohost before DONE.
// Revision : 1.0  initial release
// ============================================================================
module vscale_htif_tohost_monitor #(
  parameter int                        HTIF_PCR_WIDTH = 64,
  parameter int                        CSR_ADDR_WIDTH = 12,
  parameter logic [CSR_ADDR_WIDTH-1:0] TOHOST_ADDR    = 12'h780,
  parameter int                        POLL_GAP       = 4,
  parameter int                        CYCLE_W        = 32
) (
  input  wire logic                        clk,
  input  wire logic                        reset_n,
  input  wire logic [CYCLE_W-1:0]          max_cycles,
  vscale_htif_tohost_monitor_if.master     htif_pcr,
  output logic                             done,
  output logic                             pass,
  output logic                             timeout,
  output logic [HTIF_PCR_WIDTH-2:0]        exit_code,
  output logic [CYCLE_W-1:0]               cycle_count
);

  localparam logic [7:0] c_GAP_INIT = 8'(POLL_GAP);

  typedef enum logic [2:0] {
    S_GAP      = 3'd0,
    S_RD_REQ   = 3'd1,
    S_RD_RESP  = 3'd2,
`ifdef VSCALE_TOHOST_CLEAR_EN
    S_CLR_REQ  = 3'd3,
    S_CLR_RESP = 3'd4,
`endif
    S_DONE     = 3'd5
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [7:0]                r_gap;
  logic [7:0]                w_gap_nxt;
  logic                      r_pass_pend;
  logic                      w_pass_pend_nxt;
  logic [HTIF_PCR_WIDTH-2:0] r_code_pend;
  logic [HTIF_PCR_WIDTH-2:0] w_code_pend_nxt;
  logic [CYCLE_W-1:0]        r_cycle;
  logic                      r_timeout;
  logic                      r_done;
  logic                      r_pass;
  logic [HTIF_PCR_WIDTH-2:0] r_exit;
  logic                      r_req_valid;
  logic                      r_resp_ready;
  logic                      w_tmo_hit;
  logic                      w_rd_zero;
  logic                      w_rd_one;
  logic                      w_enter_done;
  logic                      w_req_nxt;
  logic                      w_resp_nxt;

  assign w_tmo_hit    = (max_cycles != '0) && (r_cycle == max_cycles);
  assign w_rd_zero    = (htif_pcr.resp_data == '0);
  assign w_rd_one     = (htif_pcr.resp_data == HTIF_PCR_WIDTH'(1));
  assign w_enter_done = (w_state_nxt == S_DONE) && (r_state != S_DONE);

  // r_timeout marks a budget hit in an earlier cycle; a same-cycle hit still decodes.
  always_comb begin
    w_state_nxt     = r_state;
    w_gap_nxt       = r_gap;
    w_pass_pend_nxt = r_pass_pend;
    w_code_pend_nxt = r_code_pend;
    case (r_state)
      S_GAP: begin
        if (w_tmo_hit) begin
          w_state_nxt = S_DONE;
        end else if (r_gap == 8'd0) begin
          w_state_nxt = S_RD_REQ;
        end else begin
          w_gap_nxt = r_gap - 8'd1;
        end
      end
      S_RD_REQ: begin
        if (htif_pcr.req_ready) w_state_nxt = S_RD_RESP;
      end
      S_RD_RESP: begin
        if (htif_pcr.resp_valid) begin
          if (r_timeout) begin
            w_state_nxt = S_DONE;
          end else if (w_rd_zero) begin
            if (w_tmo_hit) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_GAP;
              w_gap_nxt   = c_GAP_INIT;
            end
          end else begin
            if (w_rd_one) begin
              w_pass_pend_nxt = 1'b1;
            end else begin
              w_code_pend_nxt = htif_pcr.resp_data[HTIF_PCR_WIDTH-1:1];
            end
`ifdef VSCALE_TOHOST_CLEAR_EN
            if (w_tmo_hit) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_CLR_REQ;
            end
`else
            w_state_nxt = S_DONE;
`endif
          end
        end
      end
`ifdef VSCALE_TOHOST_CLEAR_EN
      S_CLR_REQ: begin
        if (htif_pcr.req_ready) w_state_nxt = S_CLR_RESP;
      end
      S_CLR_RESP: begin
        if (htif_pcr.resp_valid) w_state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_GAP;
        w_gap_nxt   = c_GAP_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_GAP;
      r_gap       <= c_GAP_INIT;
      r_pass_pend <= 1'b0;
      r_code_pend <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gap       <= w_gap_nxt;
      r_pass_pend <= w_pass_pend_nxt;
      r_code_pend <= w_code_pend_nxt;
    end
  end

`ifdef VSCALE_TOHOST_CLEAR_EN
  logic r_req_rw;
  assign w_req_nxt  = (w_state_nxt == S_RD_REQ)  || (w_state_nxt == S_CLR_REQ);
  assign w_resp_nxt = (w_state_nxt == S_RD_RESP) || (w_state_nxt == S_CLR_RESP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_rw <= 1'b0;
    end else begin
      r_req_rw <= (w_state_nxt == S_CLR_REQ);
    end
  end
  assign htif_pcr.req_rw = r_req_rw;
`else
  assign w_req_nxt       = (w_state_nxt == S_RD_REQ);
  assign w_resp_nxt      = (w_state_nxt == S_RD_RESP);
  assign htif_pcr.req_rw = 1'b0;
`endif

  // Handshake strobes come from the next state so they stay glitch-free flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_valid  <= 1'b0;
      r_resp_ready <= 1'b0;
      r_cycle      <= '0;
      r_timeout    <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_exit       <= '0;
    end else begin
      r_req_valid  <= w_req_nxt;
      r_resp_ready <= w_resp_nxt;
      if ((r_state != S_DONE) && !w_tmo_hit && (r_cycle != '1)) begin
        r_cycle <= r_cycle + CYCLE_W'(1);
      end
      if ((r_state != S_DONE) && w_tmo_hit) begin
        r_timeout <= 1'b1;
      end
      if (w_enter_done) begin
        r_done <= 1'b1;
        r_pass <= w_pass_pend_nxt;
        r_exit <= w_code_pend_nxt;
      end
    end
  end

  assign htif_pcr.req_valid  = r_req_valid;
  assign htif_pcr.resp_ready = r_resp_ready;
  assign htif_pcr.req_addr   = TOHOST_ADDR;
  assign htif_pcr.req_data   = '0;

  assign done        = r_done;
  assign pass        = r_pass;
  assign timeout     = r_timeout;
  assign exit_code   = r_exit;
  assign cycle_count = r_cycle;

endmodule
`default_nettype wire
